// File: rtl/fmul_pkg.sv
// Shared types and constants for the FMUL arbiter and its tag pipeline.
package fmul_pkg;

  localparam int FP_W     = 32;
  localparam int REQ_ID_W = 1;
  localparam int FMUL_LAT = 2;

  typedef struct packed {
    logic                valid;
    logic [REQ_ID_W-1:0] id;
  } fmul_tag_t;

endpackage

// File: rtl/fmul_tag_pipe.sv
// LAT-deep shift register that follows each issued multiply through the FMUL.
module fmul_tag_pipe
  import fmul_pkg::*;
#(
  parameter int LAT = FMUL_LAT
) (
  input  logic      clk,
  input  logic      clr_i,
  input  fmul_tag_t tag_i,
  output fmul_tag_t tag_o
);

  fmul_tag_t stage_q [LAT];

  always_ff @(posedge clk) begin
    if (clr_i) begin
      for (int i = 0; i < LAT; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= tag_i;
      for (int i = 1; i < LAT; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign tag_o = stage_q[LAT-1];

endmodule

// File: rtl/fmul_arbiter.sv
// Round-robin arbiter for two clients sharing one fixed-latency FMUL; routes results back by tag.
// Handshake: a request transfers on the rising edge where reqN_valid && reqN_ready; ready is combinational.
module fmul_arbiter
  import fmul_pkg::*;
#(
  parameter int LAT = FMUL_LAT,
  parameter int CW  = $clog2(LAT + 2)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req0_valid,
  input  logic            req1_valid,
  output logic            req0_ready,
  output logic            req1_ready,
  input  logic [FP_W-1:0] req0_a,
  input  logic [FP_W-1:0] req0_b,
  input  logic [FP_W-1:0] req1_a,
  input  logic [FP_W-1:0] req1_b,
  output logic [FP_W-1:0] fmul_a,
  output logic [FP_W-1:0] fmul_b,
  input  logic [FP_W-1:0] fmul_y,
  input  logic            fmul_overflow,
  input  logic            fmul_error,
  output logic            rsp0_valid,
  output logic            rsp1_valid,
  output logic [FP_W-1:0] rsp0_y,
  output logic [FP_W-1:0] rsp1_y,
  output logic            rsp0_overflow,
  output logic            rsp0_error,
  output logic            rsp1_overflow,
  output logic            rsp1_error,
  output logic [CW-1:0]   inflight0,
  output logic [CW-1:0]   inflight1,
  output logic            busy,
  output logic            dbg_rr_o
);

  logic            rr_q, rr_d;
  logic            gnt_id, issue;
  fmul_tag_t       issue_tag_q, tail_tag;
  logic [FP_W-1:0] fmul_a_q, fmul_b_q;
  logic            rsp_valid_q [2];
  logic [FP_W-1:0] rsp_y_q [2];
  logic            rsp_ovf_q [2], rsp_err_q [2];
  logic [CW-1:0]   inflight_q [2], inflight_d [2];
  logic            inc [2], dec [2];

  always_comb begin
    gnt_id = 1'b0;
    if (req0_valid && req1_valid) gnt_id = rr_q;
    else if (req1_valid)          gnt_id = 1'b1;
    issue      = !rst && (req0_valid || req1_valid);
    req0_ready = issue && !gnt_id;
    req1_ready = issue && gnt_id;
    rr_d       = issue ? ~gnt_id : rr_q;
  end

  // The issue tag sits beside the operand register, so the tail lines up with fmul_y.
  fmul_tag_pipe #(.LAT(LAT)) u_tag_pipe (
    .clk   (clk),
    .clr_i (rst),
    .tag_i (issue_tag_q),
    .tag_o (tail_tag)
  );

  always_comb begin
    for (int n = 0; n < 2; n++) begin
      inc[n]        = issue && (gnt_id == 1'(n));
      dec[n]        = tail_tag.valid && (tail_tag.id == 1'(n));
      inflight_d[n] = inflight_q[n];
      if (inc[n] && !dec[n])      inflight_d[n] = inflight_q[n] + CW'(1);
      else if (dec[n] && !inc[n]) inflight_d[n] = inflight_q[n] - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_q        <= 1'b0;
      issue_tag_q <= '0;
      fmul_a_q    <= '0;
      fmul_b_q    <= '0;
      for (int n = 0; n < 2; n++) begin
        rsp_valid_q[n] <= 1'b0;
        rsp_y_q[n]     <= '0;
        rsp_ovf_q[n]   <= 1'b0;
        rsp_err_q[n]   <= 1'b0;
        inflight_q[n]  <= '0;
      end
    end else begin
      rr_q        <= rr_d;
      issue_tag_q <= '{valid: issue, id: gnt_id};
      if (issue) begin
        fmul_a_q <= gnt_id ? req1_a : req0_a;
        fmul_b_q <= gnt_id ? req1_b : req0_b;
      end
      for (int n = 0; n < 2; n++) begin
        rsp_valid_q[n] <= dec[n];
        inflight_q[n]  <= inflight_d[n];
        if (dec[n]) begin
          rsp_y_q[n]   <= fmul_y;
          rsp_ovf_q[n] <= fmul_overflow;
          rsp_err_q[n] <= fmul_error;
        end
      end
    end
  end

  assign fmul_a        = fmul_a_q;
  assign fmul_b        = fmul_b_q;
  assign rsp0_valid    = rsp_valid_q[0];
  assign rsp1_valid    = rsp_valid_q[1];
  assign rsp0_y        = rsp_y_q[0];
  assign rsp1_y        = rsp_y_q[1];
  assign rsp0_overflow = rsp_ovf_q[0];
  assign rsp1_overflow = rsp_ovf_q[1];
  assign rsp0_error    = rsp_err_q[0];
  assign rsp1_error    = rsp_err_q[1];
  assign inflight0     = inflight_q[0];
  assign inflight1     = inflight_q[1];
  assign busy          = (inflight_q[0] != '0) || (inflight_q[1] != '0);
  assign dbg_rr_o      = rr_q;

endmodule

// File: tb/tb_fmul_arbiter.sv
// Directed bench for fmul_arbiter with a behavioural FMUL and an issue-order scoreboard.
module tb_fmul_arbiter;

  localparam int LAT = 2;
  localparam int CW  = $clog2(LAT + 2);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req0_valid = 1'b0, req1_valid = 1'b0;
  logic          req0_ready, req1_ready;
  logic [31:0]   req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic [31:0]   fmul_a, fmul_b, fmul_y;
  logic          fmul_overflow, fmul_error;
  logic          rsp0_valid, rsp1_valid;
  logic [31:0]   rsp0_y, rsp1_y;
  logic          rsp0_overflow, rsp0_error, rsp1_overflow, rsp1_error;
  logic [CW-1:0] inflight0, inflight1;
  logic          busy, dbg_rr;

  fmul_arbiter #(.LAT(LAT), .CW(CW)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
    .fmul_a(fmul_a), .fmul_b(fmul_b), .fmul_y(fmul_y),
    .fmul_overflow(fmul_overflow), .fmul_error(fmul_error),
    .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid),
    .rsp0_y(rsp0_y), .rsp1_y(rsp1_y),
    .rsp0_overflow(rsp0_overflow), .rsp0_error(rsp0_error),
    .rsp1_overflow(rsp1_overflow), .rsp1_error(rsp1_error),
    .inflight0(inflight0), .inflight1(inflight1),
    .busy(busy), .dbg_rr_o(dbg_rr)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- FMUL model: {error, overflow, y}, normal numbers, truncating ----------------
  function automatic logic [33:0] fm(input logic [31:0] a, input logic [31:0] b);
    logic        s;
    logic [47:0] p;
    logic [22:0] m;
    int          e;
    s = a[31] ^ b[31];
    if (a[30:23] == 8'hFF || b[30:23] == 8'hFF) return {2'b10, 32'h7FC00000};
    if (a[30:23] == 8'h00 || b[30:23] == 8'h00) return {2'b00, s, 31'b0};
    p = {1'b1, a[22:0]} * {1'b1, b[22:0]};
    e = int'(a[30:23]) + int'(b[30:23]) - 127;
    if (p[47]) begin m = p[46:24]; e++; end
    else m = p[45:23];
    if (e >= 255) return {2'b01, s, 8'hFF, 23'b0};
    if (e <= 0)   return {2'b00, s, 31'b0};
    return {2'b00, s, 8'(e), m};
  endfunction

  logic [33:0] fp_q [LAT];
  always @(posedge clk) begin
    fp_q[0] <= fm(fmul_a, fmul_b);
    for (int i = 1; i < LAT; i++) fp_q[i] <= fp_q[i-1];
  end
  assign {fmul_error, fmul_overflow, fmul_y} = fp_q[LAT-1];

  // ---------------- checking ----------------
  int pass_cnt = 0, chk_cnt = 0, cyc = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // ---------------- scoreboard: {id, err, ovf, y} with expected pulse edge ----------------
  logic [34:0] exp_q[$];
  int          exp_cyc_q[$];
  logic        exp_rr = 1'b0;
  logic [31:0] m_y [2];
  logic        m_ovf [2], m_err [2];

  always begin : monitor
    logic [34:0] e;
    int          c;
    logic        ev [2];
    @(posedge clk);
    cyc++;
    #1;
    ev[0] = 1'b0;
    ev[1] = 1'b0;
    if (rst) begin
      exp_q.delete();
      exp_cyc_q.delete();
      for (int n = 0; n < 2; n++) begin m_y[n] = '0; m_ovf[n] = 1'b0; m_err[n] = 1'b0; end
    end else if (exp_q.size() > 0 && exp_cyc_q[0] == cyc) begin
      e = exp_q.pop_front();
      c = exp_cyc_q.pop_front();
      ev[e[34]]    = 1'b1;
      m_y[e[34]]   = e[31:0];
      m_ovf[e[34]] = e[32];
      m_err[e[34]] = e[33];
    end
    check("rsp0_valid", rsp0_valid, ev[0]);
    check("rsp1_valid", rsp1_valid, ev[1]);
    check("rsp0_y", rsp0_y, m_y[0]);
    check("rsp1_y", rsp1_y, m_y[1]);
    check("rsp0_flags", {rsp0_error, rsp0_overflow}, {m_err[0], m_ovf[0]});
    check("rsp1_flags", {rsp1_error, rsp1_overflow}, {m_err[1], m_ovf[1]});
  end

  // ---------------- driver ----------------
  task automatic step(input logic v0, input logic [31:0] a0, input logic [31:0] b0,
                      input logic v1, input logic [31:0] a1, input logic [31:0] b1);
    int   n0, n1;
    logic e0, e1;
    n0 = 0; n1 = 0;
    foreach (exp_q[i]) if (exp_q[i][34]) n1++; else n0++;
    check("inflight0", inflight0, n0);
    check("inflight1", inflight1, n1);
    check("busy", busy, (n0 + n1) != 0);
    req0_valid = v0; req0_a = a0; req0_b = b0;
    req1_valid = v1; req1_a = a1; req1_b = b1;
    #1;
    e0 = !rst && v0 && (!v1 || exp_rr == 1'b0);
    e1 = !rst && v1 && (!v0 || exp_rr == 1'b1);
    check("req0_ready", req0_ready, e0);
    check("req1_ready", req1_ready, e1);
    if (e0) begin exp_q.push_back({1'b0, fm(a0, b0)}); exp_cyc_q.push_back(cyc + LAT + 2); end
    if (e1) begin exp_q.push_back({1'b1, fm(a1, b1)}); exp_cyc_q.push_back(cyc + LAT + 2); end
    if (rst) exp_rr = 1'b0;
    else if (e0 || e1) exp_rr = e0;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0, '0, '0);
  endtask

  function automatic logic [31:0] rnd_fp();
    logic [31:0] r;
    r[31]    = 1'($urandom_range(0, 1));
    r[30:23] = 8'($urandom_range(100, 150));
    r[22:0]  = 23'($urandom());
    return r;
  endfunction

  // ---------------- directed sequence ----------------
  initial begin
    repeat (3) @(negedge clk);
    check("reset_fmul_a", fmul_a, 32'h0);
    check("reset_rr", dbg_rr, 1'b0);
    check("reset_rsp0_y", rsp0_y, 32'h0);
    check("reset_ready", {req0_ready, req1_ready}, 2'b00);
    rst = 1'b0;
    @(negedge clk);

    // single issue: 2.0 x 3.0
    step(1'b1, 32'h40000000, 32'h40400000, 1'b0, '0, '0);
    check("single_fmul_a", fmul_a, 32'h40000000);
    check("single_inflight0", inflight0, 1);
    idle(4);
    check("single_rsp0_y", rsp0_y, 32'h40C00000);

    // contention for 6 cycles, starting from reset
    rst = 1'b1; idle(1); rst = 1'b0;
    for (int i = 0; i < 6; i++) step(1'b1, rnd_fp(), rnd_fp(), 1'b1, rnd_fp(), rnd_fp());
    idle(5);

    // single requester streaming on req1
    for (int i = 0; i < 8; i++) step(1'b0, '0, '0, 1'b1, rnd_fp(), rnd_fp());
    idle(5);

    // flag routing: overflow to rsp1, error to rsp0
    step(1'b0, '0, '0, 1'b1, 32'h7F000000, 32'h7F000000);
    idle(4);
    check("flag_rsp1_overflow", rsp1_overflow, 1'b1);
    step(1'b1, 32'h7FC00000, 32'h3F800000, 1'b0, '0, '0);
    idle(4);
    check("flag_rsp0_error", rsp0_error, 1'b1);

    // reset mid-flight
    step(1'b1, rnd_fp(), rnd_fp(), 1'b0, '0, '0);
    step(1'b0, '0, '0, 1'b1, rnd_fp(), rnd_fp());
    rst = 1'b1;
    step(1'b1, rnd_fp(), rnd_fp(), 1'b1, rnd_fp(), rnd_fp());
    rst = 1'b0;
    idle(5);
    check("post_reset_rr", dbg_rr, 1'b0);
    check("post_reset_busy", busy, 1'b0);

    // req0 streaming: issue and retire on the same edge
    for (int i = 0; i < 10; i++) step(1'b1, rnd_fp(), rnd_fp(), 1'b0, '0, '0);
    check("stream_inflight0", inflight0, LAT + 1);
    idle(5);

    // random mixed traffic
    for (int i = 0; i < 40; i++)
      step(1'($urandom_range(0, 1)), rnd_fp(), rnd_fp(), 1'($urandom_range(0, 1)), rnd_fp(), rnd_fp());
    idle(6);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/fmul_arbiter.md
# fmul_arbiter

Two-requester round-robin arbiter and sequencer for the single shared fixed-latency FMUL pipeline. It accepts operand pairs from two clients over valid/ready handshakes, issues at most one multiply per cycle into the FMUL, and tracks each issued operation with a tag pipeline. When the FMUL result emerges, the arbiter routes it, with the overflow and error flags, to the client that issued it. It sits between the client datapaths and the FMUL top, and drives the FMUL operand inputs directly.

## Interface
- `LAT`, default 2: edges from an `fmul_a`/`fmul_b` update to the matching `fmul_y`/flags being valid. Legal range 1..8.
- `CW`, default `$clog2(LAT+2)`: width of the per-requester in-flight counters.
- `clk` in 1: the single clock. All state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req0_valid`, `req1_valid` in 1: the requester has an operand pair.
- `req0_ready`, `req1_ready` out 1: grant (combinational). Transfer happens on valid&ready at the edge.
- `req0_a`, `req0_b`, `req1_a`, `req1_b` in 32: IEEE-754 single operands.
- `fmul_a`, `fmul_b` out 32: registered operands to the FMUL.
- `fmul_y` in 32: FMUL result.
- `fmul_overflow`, `fmul_error` in 1: FMUL flags, aligned with `fmul_y`.
- `rsp0_valid`, `rsp1_valid` out 1: registered one-cycle result pulse. There is no backpressure.
- `rsp0_y`, `rsp1_y` out 32: result, held until the next pulse.
- `rsp0_overflow`, `rsp0_error`, `rsp1_overflow`, `rsp1_error` out 1: flags, held like the result.
- `inflight0`, `inflight1` out CW: operations issued but not yet responded.
- `busy` out 1: high when either in-flight count is nonzero.

## Operation
- Arbitration uses a round-robin pointer `rr` (1 bit, reset 0).
  - Both requesters valid: grant `req[rr]`, then set `rr` to the other requester.
  - One requester valid: grant it, then set `rr` to the other requester.
  - Neither valid: no grant, `rr` holds.
  - Ready goes only to the granted requester. It never depends on the ungranted requester's ready.
- Issue: on a transfer, `fmul_a`/`fmul_b` load the granted operands. A tag pipeline of depth LAT shifts in `{1, id}`.
- Idle cycle: the tag pipeline shifts in `{0, x}`, and `fmul_a`/`fmul_b` hold their last value.
- Retire: when the tail entry of the tag pipeline is valid with id n, the next edge does the following:
  - loads `rspn_y`/flags from `fmul_y`/flags;
  - pulses `rspn_valid`;
  - leaves the other requester's response outputs unchanged.
- Counters: `inflightn` increments on issue for n and decrements on retire for n. Issue and retire for the same n on the same edge leave it unchanged. It can never exceed LAT+1.
- Flags are passed through unmodified. Results are never dropped once issued, except by reset.
- Reset (including mid-operation) clears:
  - `rr`;
  - all tag-pipeline valid bits, which drops in-flight operations with no response;
  - `fmul_a`, `fmul_b`, and all `rsp*` outputs (to 0);
  - the counters, and therefore `busy`.
  - `req*_ready` is 0 while `rst` is high.

## Timing
- Acceptance at edge k:
  - `fmul_a`/`fmul_b` are valid after edge k;
  - `fmul_y` is valid after edge k+LAT;
  - `rspn_valid` is high for the cycle after edge k+LAT+1.
- Total latency is LAT+1 edges. With the default LAT of 2, that is 3 cycles.
- Throughput is one multiply per cycle, shared between the two requesters. Under continuous contention each requester gets exactly every other cycle.
- Responses come back in issue order, both globally and per requester.
- Response pulses for the two requesters never coincide.

## Structure
- Package `fmul_pkg`:
  - `FP_W` = 32;
  - `REQ_ID_W` = 1;
  - a typedef `fmul_tag_t` = `{logic valid; logic id;}`;
  - the default `FMUL_LAT` = 2.
- Sub-module `fmul_tag_pipe`: a LAT-deep shift register of `fmul_tag_t` with synchronous clear.
- The arbiter, counters and response registers live in the top.

## Test plan
- Single issue: `req0` with 0x40000000 × 0x40400000 at edge k. Required: `rsp0_valid` after edge k+3, `rsp0_y` = 0x40C00000, flags 0. `inflight0` is 1 after k and 0 after k+3.
- Contention: both requesters valid for 6 cycles from reset. Required: grants alternate 0,1,0,1,0,1. Each `rspn` gets 3 pulses, in issue order.
- Single requester streaming: `req1` valid continuously. Required: `req1_ready` is 1 every cycle, and `rsp1_valid` is high continuously from cycle 4.
- Flag routing: `req1` with 0x7F000000 × 0x7F000000. Required: `rsp1_overflow` equals the FMUL overflow flag (1), and the `rsp0` outputs are unchanged.
- Reset mid-flight: issue 2 operations, then assert `rst` one edge later. Required: no `rsp` pulses, counters 0, `busy` 0, and `rr` = 0 after release.
- Simultaneous issue/retire: `req0` streaming. Required: `inflight0` stays constant at 3 (LAT+1) in steady state.
